inst_fetch_bridge: RTL
======================

Name: inst_fetch_bridge

Overview:
- Sits between the core's instruction-fetch outputs (pc, inst enable) and the instruction memory.
- Converts the core's single-cycle fetch expectation into a req/ack + rvalid handshake to a variable-latency memory.
- Holds a one-entry fetched-instruction buffer, so an address that is already buffered returns with no memory access.
- Raises a stall request to ctrl while a fetch is outstanding, and supports flush so that a stale in-flight fetch is discarded.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- inst_en_i  in  1  core fetch enable.
- inst_addr_i  in  ADDR_W  core fetch address (pc).
- flush_i  in  1  discard the buffer and any in-flight fetch (branch or exception redirect).
- inst_o  out  INST_W  instruction to if_id.
- stall_o  out  1  pause request to ctrl.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  ADDR_W  memory read address, word aligned.
- mem_ack_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  INST_W  read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, buf_valid 0, buf_tag 0, buf_data 0, mem_req_o 0, mem_addr_o 0, drop flag 0.
- Reset mid-operation: everything returns to the reset values. The memory shares rst, so no stale rvalid is expected after reset.
- Hit (combinational): hit = inst_en_i & buf_valid & (buf_tag == inst_addr_i[ADDR_W-1:2]).
- inst_o (combinational):
  - equals buf_data when hit, else 0;
  - equals 0 when inst_en_i = 0.
- stall_o (combinational): stall_o = inst_en_i & ~hit. It is not masked by flush_i.
- When inst_en_i = 0: stall_o = 0 and no new request is started. An outstanding fetch still completes and fills the buffer.
- FSM IDLE:
  - On inst_en_i & ~hit & ~flush_i, go to REQ.
  - Latch mem_addr_o <= {inst_addr_i[ADDR_W-1:2], 2'b00}.
  - mem_req_o <= 1.
- FSM REQ:
  - mem_req_o and mem_addr_o are held stable until mem_ack_i.
  - On mem_ack_i: mem_req_o <= 0; go to WAIT, or to DROP if the drop flag is set or flush_i = 1.
  - flush_i without ack sets the drop flag; the request is not withdrawn.
- FSM WAIT:
  - mem_rvalid_i is sampled only in WAIT or DROP. Memory returns rvalid no earlier than the cycle after ack.
  - On mem_rvalid_i & ~flush_i: buf_tag <= mem_addr_o[ADDR_W-1:2], buf_data <= mem_rdata_i, buf_valid <= 1; go to IDLE.
  - flush_i without rvalid: go to DROP.
  - flush_i in the same cycle as rvalid: data discarded, buffer not written, go to IDLE.
- FSM DROP: on mem_rvalid_i, discard the data, clear the drop flag, go to IDLE. Nothing is written.
- flush_i in any state: buf_valid <= 0 at the next edge.
- Simultaneous flush_i and miss in IDLE: no request is issued. The post-flush address is requested on the following cycle.
- Minimum miss latency (ack in the same cycle as req, rvalid one cycle later):
  - T0: miss, stall_o = 1.
  - T1: REQ, acked.
  - T2: WAIT, rvalid.
  - T3: hit, stall_o = 0, inst_o valid.
  - The core therefore sees 3 stall cycles.
- Address change during WAIT without flush: the fetched word still fills the buffer. Then a tag mismatch causes a new miss. This is functionally correct, only slower.
- Low two address bits are ignored for both the tag compare and mem_addr_o.

Test Plan:
- Reset asserted mid-WAIT → on the next sample, mem_req_o = 0, stall_o = 1 for inst_en_i = 1, and inst_o = 0. The buffer is cleared, so the old addr misses.
- Cold fetch addr 0x1c000000, ack immediate, rvalid one cycle later with 0x02800413 → stall_o = 1 for exactly 3 cycles, then inst_o = 0x02800413, stall_o = 0, mem_req_o held low.
- Repeat addr 0x1c000000 after the fill → hit with zero stall and no mem_req_o. Then addr 0x1c000004 → new miss, mem_addr_o = 0x1c000004.
- ack withheld 4 cycles → mem_req_o and mem_addr_o stay stable for all 5 cycles and stall_o stays 1 throughout.
- flush_i during WAIT, then rvalid with 0xdeadbeef → data discarded, buf_valid = 0. The next fetch of the same addr misses, no inst_o = 0xdeadbeef ever appears, and the FSM returns to IDLE.
- flush_i in the same cycle as rvalid, and flush_i in REQ before ack → in both cases no buffer write. The REQ case goes to DROP after ack.

Source files
------------

// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: turns single-cycle core fetches into a req/ack + rvalid memory
// handshake, with a one-entry instruction buffer, fetch stall and flush support.
module inst_fetch_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_en_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              flush_i,
  output logic [INST_W-1:0] inst_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i
);

  localparam int unsigned TagW = ADDR_W - 2;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e              state_q, state_d;
  logic                buf_valid_q, buf_valid_d;
  logic [TagW-1:0]     buf_tag_q, buf_tag_d;
  logic [INST_W-1:0]   buf_data_q, buf_data_d;
  logic                mem_req_q, mem_req_d;
  logic [TagW-1:0]     mem_tag_q, mem_tag_d;
  logic                drop_q, drop_d;
  logic                hit;
  logic                unused_addr_lsb;

  // Byte offset within the word never matters to the instruction memory.
  assign unused_addr_lsb = ^inst_addr_i[1:0];

  assign hit        = inst_en_i & buf_valid_q & (buf_tag_q == inst_addr_i[ADDR_W-1:2]);
  assign inst_o     = hit ? buf_data_q : '0;
  assign stall_o    = inst_en_i & ~hit;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = {mem_tag_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    mem_req_d   = mem_req_q;
    mem_tag_d   = mem_tag_q;
    drop_d      = drop_q;

    case (state_q)
      StIdle: begin
        if (inst_en_i && !hit && !flush_i) begin
          state_d   = StReq;
          mem_req_d = 1'b1;
          mem_tag_d = inst_addr_i[ADDR_W-1:2];
        end
      end
      StReq: begin
        // The request cannot be withdrawn; a flush only marks its response as stale.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = (drop_q || flush_i) ? StDrop : StWait;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      StWait: begin
        if (mem_rvalid_i) begin
          state_d = StIdle;
          if (!flush_i) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = mem_tag_q;
            buf_data_d  = mem_rdata_i;
          end
        end else if (flush_i) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (mem_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_tag_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      mem_req_q   <= mem_req_d;
      mem_tag_q   <= mem_tag_d;
      drop_q      <= drop_d;
    end
  end

endmodule
